wr_axi_burst_master: RTL and testbench

// - Downstream of the scaler write buffer: turns its burst request (ddr_wreq/ddr_waddr/ddr_wr_len) into AXI4 write bursts to the DDR controller.
// - Pulls beats from the buffer's show-ahead FIFO via ddr_wdata_req; signals completion via ddr_wdone so the buffer advances its line address.
// - Single ddr_clk domain; one outstanding burst at a time; AW then W then B, strictly serialised.

---
 rtl/wr_axi_burst_master.sv | 135 +++++++++++++
 tb/tb_wr_axi_burst_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_axi_burst_master.sv
// AXI4 write-burst master: turns the write buffer's level burst request into one
// serialised AW / W / B transaction, popping the show-ahead FIFO once per accepted beat.
module wr_axi_burst_master #(
    parameter int AXI_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 9,
    parameter int DATA_WIDTH     = 256
) (
    input  logic                      ddr_clk,
    input  logic                      ddr_rstn,
    input  logic                      ddr_wreq,
    input  logic [AXI_ADDR_WIDTH-1:0] ddr_waddr,
    input  logic [LEN_WIDTH-1:0]      ddr_wr_len,
    input  logic [DATA_WIDTH-1:0]     ddr_wdata,
    output logic                      ddr_wdata_req,
    output logic                      ddr_wdone,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wlast,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic                      wr_err
);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                    state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_nxt;
    logic [7:0]                awlen_nxt;
    logic [8:0]                beat_cnt, beat_cnt_nxt;
    logic                      awvalid_nxt, wvalid_nxt, wlast_nxt, bready_nxt;
    logic                      wdone_nxt, wr_err_nxt;
    logic                      beat_acc;

    // The FIFO is show-ahead, so the head word goes straight onto the bus.
    assign beat_acc      = axi_wvalid & axi_wready;
    assign ddr_wdata_req = beat_acc;
    assign axi_wdata     = ddr_wdata;
    assign axi_wstrb     = '1;

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state       <= S_IDLE;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            beat_cnt    <= '0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_wlast   <= 1'b0;
            axi_bready  <= 1'b0;
            ddr_wdone   <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state       <= state_nxt;
            axi_awaddr  <= awaddr_nxt;
            axi_awlen   <= awlen_nxt;
            beat_cnt    <= beat_cnt_nxt;
            axi_awvalid <= awvalid_nxt;
            axi_wvalid  <= wvalid_nxt;
            axi_wlast   <= wlast_nxt;
            axi_bready  <= bready_nxt;
            ddr_wdone   <= wdone_nxt;
            wr_err      <= wr_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        awaddr_nxt   = axi_awaddr;
        awlen_nxt    = axi_awlen;
        beat_cnt_nxt = beat_cnt;
        awvalid_nxt  = axi_awvalid;
        wvalid_nxt   = axi_wvalid;
        wlast_nxt    = axi_wlast;
        bready_nxt   = axi_bready;
        wdone_nxt    = 1'b0;
        wr_err_nxt   = wr_err;

        case (state)
            S_IDLE: begin
                // The wdone cycle is skipped so the buffer can advance its address first.
                if (ddr_wreq && !ddr_wdone) begin
                    if (ddr_wr_len == '0) begin
                        wr_err_nxt = 1'b1;
                    end else begin
                        awaddr_nxt  = ddr_waddr;
                        awlen_nxt   = 8'(ddr_wr_len - LEN_WIDTH'(1));
                        awvalid_nxt = 1'b1;
                        state_nxt   = S_AW;
                    end
                end
            end
            S_AW: begin
                if (axi_awready) begin
                    awvalid_nxt  = 1'b0;
                    wvalid_nxt   = 1'b1;
                    beat_cnt_nxt = '0;
                    wlast_nxt    = (axi_awlen == 8'd0);
                    state_nxt    = S_W;
                end
            end
            S_W: begin
                if (beat_acc) begin
                    if (axi_wlast) begin
                        wvalid_nxt = 1'b0;
                        wlast_nxt  = 1'b0;
                        bready_nxt = 1'b1;
                        state_nxt  = S_B;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 9'd1;
                        wlast_nxt    = ((beat_cnt + 9'd1) == {1'b0, axi_awlen});
                    end
                end
            end
            S_B: begin
                if (axi_bvalid) begin
                    bready_nxt = 1'b0;
                    wdone_nxt  = 1'b1;
                    state_nxt  = S_IDLE;
                    if (axi_bresp != 2'b00) begin
                        wr_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wr_axi_burst_master.sv
// Directed bench for wr_axi_burst_master: an AXI slave / FIFO model checks every AW and
// W beat against a scoreboard filled when each burst request is driven.
module tb_wr_axi_burst_master;

    localparam int AW = 28;
    localparam int LW = 9;
    localparam int DW = 64;

    typedef struct { logic [63:0] d; logic last; } beat_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] l; } aw_t;

    logic          ddr_clk = 1'b0;
    logic          ddr_rstn = 1'b0;
    logic          ddr_wreq = 1'b0;
    logic [AW-1:0] ddr_waddr = '0;
    logic [LW-1:0] ddr_wr_len = '0;
    logic [DW-1:0] ddr_wdata;
    logic          ddr_wdata_req, ddr_wdone;
    logic [AW-1:0] axi_awaddr;
    logic [7:0]    axi_awlen;
    logic          axi_awvalid;
    logic          axi_awready = 1'b0;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic          axi_wlast, axi_wvalid;
    logic          axi_wready = 1'b0;
    logic [1:0]    axi_bresp = 2'b00;
    logic          axi_bvalid = 1'b0;
    logic          axi_bready, wr_err;

    always #5 ddr_clk = ~ddr_clk;

    wr_axi_burst_master #(.AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) dut (
        .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn), .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr),
        .ddr_wr_len(ddr_wr_len), .ddr_wdata(ddr_wdata), .ddr_wdata_req(ddr_wdata_req),
        .ddr_wdone(ddr_wdone), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .wr_err(wr_err)
    );

    int          n_cmp = 0, n_fail = 0;
    int          aw_cnt = 0, pop_cnt = 0, wdone_cnt = 0;
    int          p0, a0, d0, nw;
    bit          pop_pending = 1'b0, aw_stall = 1'b0, toggle_mode = 1'b0;
    logic [1:0]  bresp_val = 2'b00;
    logic [31:0] fifo_head = 32'h1000;
    logic [31:0] exp_next = 32'h1000;
    beat_t       bq[$];
    aw_t         awq[$];
    beat_t       sl_beat;
    aw_t         sl_aw;

    assign ddr_wdata = {~fifo_head, fifo_head};

    function automatic logic [63:0] word(input logic [31:0] h);
        return {~h, h};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic [AW-1:0] a, input int len);
        aw_t   e;
        beat_t b;
        e.a = a;
        e.l = 8'(len - 1);
        awq.push_back(e);
        for (int i = 0; i < len; i++) begin
            b.d    = word(exp_next);
            b.last = (i == len - 1);
            bq.push_back(b);
            exp_next = exp_next + 1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge ddr_clk);
            #3;
        end
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input int len);
        cycles(1);
        ddr_waddr  = a;
        ddr_wr_len = LW'(len);
        ddr_wreq   = 1'b1;
        push_burst(a, len);
        @(posedge ddr_clk);
        #1;
        chk("awvalid_latency", 64'(axi_awvalid), 64'd1);
        ddr_wreq = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (wdone_cnt < target && n < 2000) begin
            cycles(1);
            n++;
        end
        chk(tag, 64'(wdone_cnt), 64'(target));
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_awvalid"}, 64'(axi_awvalid), 64'd0);
        chk({pfx, "_wvalid"},  64'(axi_wvalid),  64'd0);
        chk({pfx, "_wlast"},   64'(axi_wlast),   64'd0);
        chk({pfx, "_bready"},  64'(axi_bready),  64'd0);
        chk({pfx, "_wdone"},   64'(ddr_wdone),   64'd0);
        chk({pfx, "_wr_err"},  64'(wr_err),      64'd0);
        chk({pfx, "_pop"},     64'(ddr_wdata_req), 64'd0);
        chk({pfx, "_awaddr"},  64'(axi_awaddr),  64'd0);
        chk({pfx, "_awlen"},   64'(axi_awlen),   64'd0);
    endtask

    // Slave and FIFO model: inputs change on the falling edge, handshakes are judged just after.
    initial begin
        forever begin
            @(negedge ddr_clk);
            if (pop_pending) begin
                fifo_head   = fifo_head + 1;
                pop_pending = 1'b0;
            end
            axi_awready = !aw_stall;
            axi_wready  = toggle_mode ? !axi_wready : 1'b1;
            axi_bvalid  = axi_bready;
            axi_bresp   = bresp_val;
            #1;
            if (ddr_rstn) begin
                if (axi_awvalid && axi_awready) begin
                    aw_cnt++;
                    if (awq.size() > 0) begin
                        sl_aw = awq.pop_front();
                        chk("awaddr", 64'(axi_awaddr), 64'(sl_aw.a));
                        chk("awlen",  64'(axi_awlen),  64'(sl_aw.l));
                    end else begin
                        chk("aw_unexpected", 64'd1, 64'd0);
                    end
                end
                if (axi_wvalid && axi_wready) begin
                    chk("pop_on_beat", 64'(ddr_wdata_req), 64'd1);
                    pop_cnt++;
                    pop_pending = 1'b1;
                    if (bq.size() > 0) begin
                        sl_beat = bq.pop_front();
                        chk("wdata", axi_wdata, sl_beat.d);
                        chk("wlast", 64'(axi_wlast), 64'(sl_beat.last));
                    end else begin
                        chk("beat_unexpected", 64'd1, 64'd0);
                    end
                end else if (ddr_wdata_req) begin
                    chk("spurious_pop", 64'(ddr_wdata_req), 64'd0);
                end
                if (ddr_wdone) wdone_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge ddr_clk);
        #3;
        chk_all_zero("reset");
        ddr_rstn = 1'b1;

        // Single burst, AW stalled for a few cycles.
        aw_stall = 1'b1;
        p0 = pop_cnt;
        start_burst(28'h100, 32);
        repeat (3) begin
            @(posedge ddr_clk);
            #1;
            chk("aw_hold_valid", 64'(axi_awvalid), 64'd1);
            chk("aw_hold_addr",  64'(axi_awaddr),  64'h100);
        end
        aw_stall = 1'b0;
        wait_done(1, "t1_wdone");
        chk("t1_pops", 64'(pop_cnt - p0), 64'd32);
        chk("t1_sb_empty", 64'(bq.size()), 64'd0);
        chk("wstrb", 64'(axi_wstrb), 64'hFF);
        @(posedge ddr_clk);
        #1;
        chk("wdone_one_cycle", 64'(ddr_wdone), 64'd0);

        // wready toggling every cycle.
        toggle_mode = 1'b1;
        p0 = pop_cnt;
        start_burst(28'h200, 32);
        wait_done(2, "t2_wdone");
        chk("t2_pops", 64'(pop_cnt - p0), 64'd32);
        toggle_mode = 1'b0;

        // Back-to-back with wreq held; the address advances during the wdone cycle.
        cycles(1);
        a0 = aw_cnt;
        push_burst(28'd0, 16);
        push_burst(28'd256, 16);
        ddr_waddr  = 28'd0;
        ddr_wr_len = LW'(16);
        ddr_wreq   = 1'b1;
        wait_done(3, "b2b_first_wdone");
        ddr_waddr = 28'd256;
        wait_done(4, "b2b_second_wdone");
        ddr_wreq = 1'b0;
        cycles(3);
        chk("b2b_aw_count", 64'(aw_cnt - a0), 64'd2);
        chk("b2b_awq_empty", 64'(awq.size()), 64'd0);

        // wreq re-raised during W must not start a second burst.
        a0 = aw_cnt;
        start_burst(28'h300, 16);
        nw = 0;
        while (!axi_wvalid && nw < 50) begin
            cycles(1);
            nw++;
        end
        chk("t4_in_w", 64'(axi_wvalid), 64'd1);
        ddr_wreq = 1'b1;
        cycles(4);
        ddr_wreq = 1'b0;
        wait_done(5, "t4_wdone");
        cycles(3);
        chk("t4_one_aw", 64'(aw_cnt - a0), 64'd1);

        // SLVERR response: wdone still pulses, error is sticky.
        bresp_val = 2'b10;
        start_burst(28'h400, 4);
        wait_done(6, "t5_wdone");
        chk("t5_wr_err", 64'(wr_err), 64'd1);
        bresp_val = 2'b00;
        start_burst(28'h500, 4);
        wait_done(7, "t5b_wdone");
        chk("t5_wr_err_sticky", 64'(wr_err), 64'd1);

        // Reset in the middle of the W phase.
        p0 = pop_cnt;
        start_burst(28'h600, 32);
        nw = 0;
        while ((pop_cnt - p0) < 10 && nw < 200) begin
            cycles(1);
            nw++;
        end
        chk("t6_ten_beats", 64'(pop_cnt - p0), 64'd10);
        ddr_rstn    = 1'b0;
        pop_pending = 1'b0;
        bq.delete();
        awq.delete();
        exp_next = fifo_head;
        #1;
        chk_all_zero("midrst");
        cycles(2);
        ddr_rstn = 1'b1;
        cycles(1);

        p0 = pop_cnt;
        start_burst(28'h700, 8);
        wait_done(8, "t7_wdone");
        chk("t7_pops", 64'(pop_cnt - p0), 64'd8);
        chk("t7_wr_err_clear", 64'(wr_err), 64'd0);

        // Zero-length request: error only, no AXI traffic.
        cycles(1);
        a0 = aw_cnt;
        d0 = wdone_cnt;
        ddr_wr_len = '0;
        ddr_wreq   = 1'b1;
        @(posedge ddr_clk);
        #1;
        chk("len0_wr_err", 64'(wr_err), 64'd1);
        chk("len0_no_awvalid", 64'(axi_awvalid), 64'd0);
        ddr_wreq = 1'b0;
        cycles(5);
        chk("len0_no_aw", 64'(aw_cnt - a0), 64'd0);
        chk("len0_no_wdone", 64'(wdone_cnt - d0), 64'd0);
        chk("len0_awvalid_low", 64'(axi_awvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
